// File: rtl/iq_pkg.sv
// Shared constants and helpers for the IQ modulator/demodulator pair.
// Holds the ADC and table zero codes, datapath widths, the quarter-wave
// sine table with its full-turn sin/cos lookups, and the 8-bit clamp.
package iq_pkg;

   localparam int ADC_W     = 10;
   localparam int TAB_W     = 8;
   localparam int TAB_DEPTH = 256;
   localparam int SAMP_W    = ADC_W + 1;
   localparam int PROD_W    = SAMP_W + TAB_W;

   localparam logic [ADC_W-1:0] ADC_ZERO = 10'd512;
   localparam logic [TAB_W-1:0] TAB_ZERO = 8'd128;

   // round(127 * sin(2*pi*k/256)) for k = 0..64; the other three quadrants
   // are folded onto this quarter.
   localparam logic [6:0] QSIN [0:64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };

   // Sine of a phase in 1/256 turn, offset binary (128 = zero).
   function automatic logic [TAB_W-1:0] sin_ob(input logic [7:0] ph);
      logic [6:0] k;
      logic [6:0] mag;
      k   = ph[6] ? (7'd64 - {1'b0, ph[5:0]}) : {1'b0, ph[5:0]};
      mag = QSIN[k];
      return ph[7] ? (TAB_ZERO - {1'b0, mag}) : (TAB_ZERO + {1'b0, mag});
   endfunction

   function automatic logic [TAB_W-1:0] cos_ob(input logic [7:0] ph);
      return sin_ob(ph + 8'd64);
   endfunction

   // Offset binary to two's complement: flip the MSB.
   function automatic logic [TAB_W-1:0] ob_to_signed(input logic [TAB_W-1:0] ob);
      return {~ob[TAB_W-1], ob[TAB_W-2:0]};
   endfunction

   // Clamp a signed value to [-128, +127].
   function automatic logic [7:0] sat8(input logic signed [31:0] v);
      if (v > 32'sd127)
         return 8'h7f;
      if (v < -32'sd128)
         return 8'h80;
      return v[7:0];
   endfunction

endpackage

// File: rtl/iq_demod_nco.sv
// Local oscillator for the demodulator: 8-bit phase accumulator plus the
// shared sin/cos table.
//   clk, reset_   clock, async active-low reset
//   enable        advance phase by PHASE_INC this clock
//   phase         registered phase, 1/256 turn
//   lut_phase     phase to look up (combinational)
//   cos_s, sin_s  table outputs for lut_phase, two's complement
module iq_demod_nco
   import iq_pkg::*;
#(
   parameter int unsigned PHASE_INC = 8
) (
   input  logic                      clk,
   input  logic                      reset_,
   input  logic                      enable,
   output logic [$clog2(TAB_DEPTH)-1:0] phase,
   input  logic [$clog2(TAB_DEPTH)-1:0] lut_phase,
   output logic signed [TAB_W-1:0]   cos_s,
   output logic signed [TAB_W-1:0]   sin_s
);

   localparam int PH_W = $clog2(TAB_DEPTH);
   localparam logic [PH_W-1:0] STEP = PH_W'(PHASE_INC);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         phase <= '0;
      else if (enable)
         phase <= phase + STEP;
   end

   assign cos_s = ob_to_signed(cos_ob(lut_phase));
   assign sin_s = ob_to_signed(sin_ob(lut_phase));

endmodule

// File: rtl/iq_demod.sv
// Quadrature demodulator: mixes offset-binary ADC samples with a local
// sin/cos NCO, integrates DECIM products per window (accumulate-and-dump)
// and presents one saturated signed I/Q pair per window on valid/ready.
//   clk, reset_   clock, async active-low reset
//   enable        sample, mix and advance the NCO this clock
//   adcval        ADC sample, offset binary (512 = zero)
//   i, q          result, two's complement
//   iq_valid      i/q hold a result not yet accepted
//   iq_ready      consumer accepts i/q when high with iq_valid
//   overrun       sticky: a result was overwritten before acceptance
module iq_demod
   import iq_pkg::*;
#(
   parameter int unsigned PHASE_INC = 8,
   parameter int unsigned DECIM     = 32,
   parameter int unsigned OUT_SHIFT = 11
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             enable,
   input  logic [ADC_W-1:0] adcval,
   output logic [7:0]       i,
   output logic [7:0]       q,
   output logic             iq_valid,
   input  logic             iq_ready,
   output logic             overrun
);

   localparam int CNT_W = $clog2(DECIM);
   localparam int ACC_W = PROD_W + CNT_W + 1;
   localparam int PH_W  = $clog2(TAB_DEPTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

   logic [PH_W-1:0]          nco_phase;
   logic signed [TAB_W-1:0]  cos_s, sin_s;

   logic                     s1_v;
   logic signed [SAMP_W-1:0] s1_samp;
   logic [PH_W-1:0]          s1_phase;

   logic signed [PROD_W-1:0] samp_x, cos_x, sin_x, prod_i, prod_q;
   logic                     s2_v;
   logic signed [PROD_W-1:0] s2_pi, s2_pq;

   logic [CNT_W-1:0]         win_cnt;
   logic signed [ACC_W-1:0]  acc_i, acc_q, sum_i, sum_q;

   logic                     dump_v;
   logic signed [ACC_W-1:0]  dump_i, dump_q, shr_i, shr_q;
   logic                     sat_v;
   logic [7:0]               sat_i, sat_q;

   iq_demod_nco #(.PHASE_INC(PHASE_INC)) u_nco (
      .clk       (clk),
      .reset_    (reset_),
      .enable    (enable),
      .phase     (nco_phase),
      .lut_phase (s1_phase),
      .cos_s     (cos_s),
      .sin_s     (sin_s)
   );

   // S1: center the sample and pair it with the phase it was taken at.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         s1_v     <= 1'b0;
         s1_samp  <= '0;
         s1_phase <= '0;
      end else begin
         s1_v     <= enable;
         s1_samp  <= $signed({1'b0, adcval}) - $signed({1'b0, ADC_ZERO});
         s1_phase <= nco_phase;
      end
   end

   // S2: mix. Q is negated so a modulator q input comes back with its own sign.
   assign samp_x = {{(PROD_W-SAMP_W){s1_samp[SAMP_W-1]}}, s1_samp};
   assign cos_x  = {{(PROD_W-TAB_W){cos_s[TAB_W-1]}}, cos_s};
   assign sin_x  = {{(PROD_W-TAB_W){sin_s[TAB_W-1]}}, sin_s};
   assign prod_i = samp_x * cos_x;
   assign prod_q = -(samp_x * sin_x);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         s2_v  <= 1'b0;
         s2_pi <= '0;
         s2_pq <= '0;
      end else begin
         s2_v  <= s1_v;
         s2_pi <= prod_i;
         s2_pq <= prod_q;
      end
   end

   // S3: accumulate; the last product of a window is folded into the dumped
   // sum rather than the accumulator, which restarts from zero.
   assign sum_i = acc_i + {{(ACC_W-PROD_W){s2_pi[PROD_W-1]}}, s2_pi};
   assign sum_q = acc_q + {{(ACC_W-PROD_W){s2_pq[PROD_W-1]}}, s2_pq};

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         win_cnt <= '0;
         acc_i   <= '0;
         acc_q   <= '0;
         dump_v  <= 1'b0;
         dump_i  <= '0;
         dump_q  <= '0;
      end else begin
         dump_v <= 1'b0;
         if (s2_v) begin
            if (win_cnt == LAST) begin
               dump_i  <= sum_i;
               dump_q  <= sum_q;
               dump_v  <= 1'b1;
               acc_i   <= '0;
               acc_q   <= '0;
               win_cnt <= '0;
            end else begin
               acc_i   <= sum_i;
               acc_q   <= sum_q;
               win_cnt <= win_cnt + 1'b1;
            end
         end
      end
   end

   // Scale and clamp in their own stage, keeping the wide add and the
   // clamp off the same path; i/q land four clocks after the S1 edge.
   assign shr_i = dump_i >>> OUT_SHIFT;
   assign shr_q = dump_q >>> OUT_SHIFT;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sat_v <= 1'b0;
         sat_i <= '0;
         sat_q <= '0;
      end else begin
         sat_v <= dump_v;
         if (dump_v) begin
            sat_i <= sat8({{(32-ACC_W){shr_i[ACC_W-1]}}, shr_i});
            sat_q <= sat8({{(32-ACC_W){shr_q[ACC_W-1]}}, shr_q});
         end
      end
   end

   // Output holding register. A new result always wins; it only counts as an
   // overrun if the previous one is still pending and not taken this clock.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         i        <= '0;
         q        <= '0;
         iq_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (sat_v) begin
            i        <= sat_i;
            q        <= sat_q;
            iq_valid <= 1'b1;
            if (iq_valid && !iq_ready)
               overrun <= 1'b1;
         end else if (iq_ready) begin
            iq_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iq_demod.sv
module tb_iq_demod;
   import iq_pkg::*;

   localparam int DECIM     = 32;
   localparam int PHASE_INC = 8;
   localparam int SHIFT     = 11;

   logic       clk = 1'b0;
   logic       reset_;
   logic       enable;
   logic [9:0] adcval;
   logic       iq_ready;
   logic       ready_hi;
   logic [7:0] i_m, q_m, i_s, q_s;
   logic       v_m, v_s, ov_m, ov_s;

   always #5 clk = ~clk;

   iq_demod #(.PHASE_INC(PHASE_INC), .DECIM(DECIM), .OUT_SHIFT(SHIFT)) dut (
      .clk(clk), .reset_(reset_), .enable(enable), .adcval(adcval),
      .i(i_m), .q(q_m), .iq_valid(v_m), .iq_ready(iq_ready), .overrun(ov_m));

   iq_demod #(.PHASE_INC(PHASE_INC), .DECIM(DECIM), .OUT_SHIFT(0)) dut_sat (
      .clk(clk), .reset_(reset_), .enable(enable), .adcval(adcval),
      .i(i_s), .q(q_s), .iq_valid(v_s), .iq_ready(ready_hi), .overrun(ov_s));

   typedef struct { int i; int q; } res_t;
   res_t exp_m[$];
   res_t exp_s[$];
   res_t em, es;

   int checks = 0;
   int errors = 0;
   int valid_cycles = 0;

   // reference model state
   int ph, acc_i, acc_q, cnt;

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      ph = 0; acc_i = 0; acc_q = 0; cnt = 0;
   endtask

   task automatic model_sample(input int adc);
      int s, c, sn;
      res_t r;
      s  = adc - 512;
      c  = int'(cos_ob(8'(ph))) - 128;
      sn = int'(sin_ob(8'(ph))) - 128;
      acc_i += s * c;
      acc_q += -(s * sn);
      cnt++;
      ph = (ph + PHASE_INC) % 256;
      if (cnt == DECIM) begin
         r.i = sat(acc_i >>> SHIFT); r.q = sat(acc_q >>> SHIFT);
         exp_m.push_back(r);
         r.i = sat(acc_i); r.q = sat(acc_q);
         exp_s.push_back(r);
         acc_i = 0; acc_q = 0; cnt = 0;
      end
   endtask

   // 0 DC, 1 cos tone, 2 sin tone (sign chosen to give +q), 3 inverted cos, else random
   function automatic logic [9:0] tone(input int mode);
      int c, sn, v;
      c  = int'(cos_ob(8'(ph))) - 128;
      sn = int'(sin_ob(8'(ph))) - 128;
      case (mode)
         0: v = 512;
         1: v = 512 + c;
         2: v = 512 - sn;
         3: v = 512 - c;
         default: v = int'($urandom_range(0, 1023));
      endcase
      return 10'(v);
   endfunction

   task automatic cyc(input logic en, input logic [9:0] adc);
      enable = en;
      adcval = adc;
      if (en) model_sample(int'(adc));
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int mode, input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, tone(mode));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 10'd512);
   endtask

   // After the last sample of a window: not visible after 3 clocks, visible after 4.
   task automatic check_latency(input string name);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 10'd512);
         if (k == 3) check({name, "_early"}, int'(v_m), 0);
         if (k == 4) check(name, int'(v_m), 1);
      end
   endtask

   // Scoreboard monitor: compares whenever a result is being accepted.
   always @(negedge clk) begin
      if (reset_) begin
         if (v_m) valid_cycles++;
         if (v_m && iq_ready) begin
            if (exp_m.size() == 0) begin
               checks++; errors++;
               $display("FAIL main_unexpected: got result i=%0d with none expected", $signed(i_m));
            end else begin
               em = exp_m.pop_front();
               check("main_i", int'($signed(i_m)), em.i);
               check("main_q", int'($signed(q_m)), em.q);
            end
         end
         if (v_s && ready_hi) begin
            if (exp_s.size() == 0) begin
               checks++; errors++;
               $display("FAIL sat_unexpected: got result i=%0d with none expected", $signed(i_s));
            end else begin
               es = exp_s.pop_front();
               check("sat_i", int'($signed(i_s)), es.i);
               check("sat_q", int'($signed(q_s)), es.q);
            end
         end
      end
   end

   initial begin
      #200000;
      checks++; errors++;
      $display("FAIL timeout: bench did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int v0;
      reset_ = 1'b0; enable = 1'b0; adcval = 10'd512;
      iq_ready = 1'b1; ready_hi = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_i", int'(i_m), 0);
      check("rst_q", int'(q_m), 0);
      check("rst_valid", int'(v_m), 0);
      check("rst_overrun", int'(ov_m), 0);
      reset_ = 1'b1;

      // DC: zero results, one valid cycle per window
      v0 = valid_cycles;
      run(0, 3 * DECIM);
      idle(6);
      check("dc_pulses", valid_cycles - v0, 3);
      check("dc_overrun", int'(ov_m), 0);

      // tones, inverted tone, random
      run(1, 2 * DECIM);
      run(2, 2 * DECIM);
      run(3, DECIM);
      run(4, 4 * DECIM);
      idle(6);

      // enable dropped for 10 clocks mid-window
      run(1, 16);
      idle(10);
      run(1, 16);
      check_latency("pause_latency");
      idle(2);

      // backpressure across two windows
      iq_ready = 1'b0;
      run(1, DECIM);
      idle(5);
      check("bp_valid1", int'(v_m), 1);
      check("bp_first_i", int'($signed(i_m)), exp_m[0].i);
      check("bp_first_q", int'($signed(q_m)), exp_m[0].q);
      check("bp_overrun1", int'(ov_m), 0);
      run(4, DECIM);
      check("bp_frozen_i", int'($signed(i_m)), exp_m[0].i);
      idle(5);
      check("bp_valid2", int'(v_m), 1);
      check("bp_second_i", int'($signed(i_m)), exp_m[1].i);
      check("bp_second_q", int'($signed(q_m)), exp_m[1].q);
      check("bp_overrun2", int'(ov_m), 1);
      void'(exp_m.pop_front());
      iq_ready = 1'b1;
      cyc(1'b0, 10'd512);
      check("bp_drop", int'(v_m), 0);
      check("bp_overrun_sticky", int'(ov_m), 1);

      // asynchronous reset mid-window with a pending result
      iq_ready = 1'b0;
      run(1, DECIM);
      idle(5);
      run(1, 17);
      #2;
      reset_ = 1'b0;
      #1;
      check("async_i", int'(i_m), 0);
      check("async_q", int'(q_m), 0);
      check("async_valid", int'(v_m), 0);
      check("async_overrun", int'(ov_m), 0);
      exp_m.delete();
      exp_s.delete();
      model_reset();
      @(posedge clk);
      #1;
      reset_ = 1'b1;
      iq_ready = 1'b1;
      run(1, DECIM);
      check_latency("post_reset_latency");
      idle(6);

      check("main_drained", exp_m.size(), 0);
      check("sat_drained", exp_s.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
